// File: rtl/ctrl_types_pkg.sv
// Shared controller-side types: operation codes, host response status and
// the host-interface FSM state encoding.
// Latency: n/a (types only). Backpressure: n/a.
package ctrl_types_pkg;

  typedef enum logic [1:0] {
    NOOP   = 2'd0,
    READ   = 2'd1,
    UPSERT = 2'd2,
    DELETE = 2'd3
  } operation_e;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    MISS    = 2'd1,
    TIMEOUT = 2'd2,
    ILLEGAL = 2'd3
  } resp_status_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } if_state_e;

  // Read data is only meaningful for a READ the controller completed.
  function automatic logic returns_data(operation_e op, logic succ);
    return (op == READ) && succ;
  endfunction

endpackage

// File: rtl/cache_host_if_rdy_edge_timeout.sv
// Rising-edge detector on the controller ready plus a saturating WAIT timeout counter.
// Latency: edge/expired are combinational from rdy and the registered history.
// Backpressure: none; clear loads the ready history, en advances detector and counter.
//
// Ports: clk, rst (async active-high); clear (ISSUE cycle), en (WAIT cycles),
//        rdy (controller ready level); rdy_edge (rdy & ~rdy_q while en),
//        expired (counter at its last WAIT cycle while en).
module rdy_edge_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic rdy,
  output logic rdy_edge,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  logic          rdy_q, rdy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    rdy_d = rdy_q;
    cnt_d = cnt_q;
    if (clear) begin
      // Loading the current level means a ready that is already high
      // before WAIT is not mistaken for a completion.
      rdy_d = rdy;
      cnt_d = '0;
    end else if (en) begin
      rdy_d = rdy;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rdy_q <= rdy_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdy_edge = en & rdy & ~rdy_q;
  // Raw expiry; the caller gives a simultaneous edge priority.
  assign expired  = en & (cnt_q == CNT_LAST);

endmodule

// File: rtl/cache_host_if.sv
// Host command interface: one request at a time, issued as a one-cycle op pulse,
// response latched on the controller ready rising edge. Latency: accept->pulse 1, edge->resp_valid 1.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
//
// Ports: req_* (host request handshake), resp_* (host response handshake),
//        ctrl_op_out/key_out/value_out (to controller/memory),
//        ctrl_rdy_in/ctrl_op_succ_in/rd_value_in (from controller/memory), busy.
module cache_host_if
  import ctrl_types_pkg::*;
#(
  parameter int KEY_WIDTH      = 16,
  parameter int VALUE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  operation_e             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output resp_status_e           resp_status,
  output logic [VALUE_WIDTH-1:0] resp_value,
  output operation_e             ctrl_op_out,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic [VALUE_WIDTH-1:0] value_out,
  input  logic                   ctrl_rdy_in,
  input  logic                   ctrl_op_succ_in,
  input  logic [VALUE_WIDTH-1:0] rd_value_in,
  output logic                   busy
);

  if_state_e              state_q, state_d;
  operation_e             op_q, op_d;
  operation_e             ctrl_op_q, ctrl_op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  resp_status_e           resp_status_q, resp_status_d;
  logic [VALUE_WIDTH-1:0] resp_value_q, resp_value_d;

  logic tmr_clear, tmr_en, rdy_edge, expired;

  assign tmr_clear = (state_q == ISSUE);
  assign tmr_en    = (state_q == WAIT);

  rdy_edge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rdy_edge_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .rdy     (ctrl_rdy_in),
    .rdy_edge(rdy_edge),
    .expired (expired)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    ctrl_op_d     = ctrl_op_q;
    key_d         = key_q;
    value_d       = value_q;
    resp_status_d = resp_status_q;
    resp_value_d  = resp_value_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          key_d   = req_key;
          value_d = req_value;
          if (req_op == NOOP) begin
            state_d       = RESP;
            resp_status_d = ILLEGAL;
            resp_value_d  = '0;
          end else begin
            // Registered so the pulse lines up with the ISSUE cycle.
            state_d   = ISSUE;
            ctrl_op_d = req_op;
          end
        end
      end
      ISSUE: begin
        // Drop the op after one cycle so the controller cannot re-enter it.
        ctrl_op_d = NOOP;
        state_d   = WAIT;
      end
      WAIT: begin
        if (rdy_edge) begin
          state_d       = RESP;
          resp_status_d = ctrl_op_succ_in ? OK : MISS;
          resp_value_d  = returns_data(op_q, ctrl_op_succ_in) ? rd_value_in : '0;
        end else if (expired) begin
          state_d       = RESP;
          resp_status_d = TIMEOUT;
          resp_value_d  = '0;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= NOOP;
      ctrl_op_q     <= NOOP;
      key_q         <= '0;
      value_q       <= '0;
      resp_status_q <= OK;
      resp_value_q  <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      ctrl_op_q     <= ctrl_op_d;
      key_q         <= key_d;
      value_q       <= value_d;
      resp_status_q <= resp_status_d;
      resp_value_q  <= resp_value_d;
    end
  end

  // Gated by rst so no request is taken while reset is still asserted.
  assign req_ready   = (state_q == IDLE) & ~rst;
  assign resp_valid  = (state_q == RESP);
  assign resp_status = resp_status_q;
  assign resp_value  = resp_value_q;
  assign ctrl_op_out = ctrl_op_q;
  assign key_out     = key_q;
  assign value_out   = value_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cache_host_if.sv
// Randomized bench for cache_host_if with a transaction-level reference model.
// Latency: n/a. Backpressure: response stalls driven from the stimulus.
module tb_cache_host_if;
  import ctrl_types_pkg::*;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  operation_e   req_op;
  logic [15:0]  req_key;
  logic [31:0]  req_value;
  logic         resp_valid;
  logic         resp_ready;
  resp_status_e resp_status;
  logic [31:0]  resp_value;
  operation_e   ctrl_op_out;
  logic [15:0]  key_out;
  logic [31:0]  value_out;
  logic         ctrl_rdy_in;
  logic         ctrl_op_succ_in;
  logic [31:0]  rd_value_in;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  cache_host_if #(
    .KEY_WIDTH(16),
    .VALUE_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_key        (req_key),
    .req_value      (req_value),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_status    (resp_status),
    .resp_value     (resp_value),
    .ctrl_op_out    (ctrl_op_out),
    .key_out        (key_out),
    .value_out      (value_out),
    .ctrl_rdy_in    (ctrl_rdy_in),
    .ctrl_op_succ_in(ctrl_op_succ_in),
    .rd_value_in    (rd_value_in),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Index of the first WAIT cycle whose ready level is high after a low level
  // (the level seen in ISSUE counts as the level before WAIT cycle 0); -1 if none.
  function automatic int first_rise(input bit pre, input bit [TO-1:0] pat);
    bit prev;
    prev = pre;
    for (int i = 0; i < TO; i++) begin
      if (pat[i] && !prev) return i;
      prev = pat[i];
    end
    return -1;
  endfunction

  task automatic run_txn(input operation_e op, input logic [15:0] key, input logic [31:0] val,
                         input bit pre, input bit [TO-1:0] pat, input bit succ,
                         input logic [31:0] rdv, input int stall, input bit hold_req);
    int           e;
    int           exp_wait;
    int           got_wait;
    int           pulses;
    resp_status_e exp_st;
    logic [31:0]  exp_val;

    e = first_rise(pre, pat);
    if (op == NOOP) begin
      exp_st = ILLEGAL; exp_val = '0; exp_wait = 0;
    end else if (e >= 0) begin
      exp_st   = succ ? OK : MISS;
      exp_val  = (op == READ && succ) ? rdv : 32'h0;
      exp_wait = e + 1;
    end else begin
      exp_st = TIMEOUT; exp_val = '0; exp_wait = TO;
    end
    pulses = 0;

    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_key = key; req_value = val;
    ctrl_rdy_in = pre;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = operation_e'($urandom_range(0, 3));
    req_key   = 16'($urandom);
    req_value = $urandom;
    if (ctrl_op_out != NOOP) pulses++;
    chk("accept_busy", busy, 1);
    chk("accept_req_ready", req_ready, 0);
    chk("key_out_latched", key_out, key);
    chk("value_out_latched", value_out, val);
    if (op != NOOP) begin
      chk("op_pulse", ctrl_op_out, op);
      // ISSUE cycle keeps the pre level; step into WAIT cycle 0.
      @(posedge clk); #1;
      if (ctrl_op_out != NOOP) pulses++;
    end

    got_wait = 0;
    while (!resp_valid && got_wait < TO + 4) begin
      ctrl_rdy_in     = (got_wait < TO) ? pat[got_wait] : 1'b0;
      ctrl_op_succ_in = succ;
      rd_value_in     = rdv;
      chk("wait_op_noop", ctrl_op_out, NOOP);
      @(posedge clk); #1;
      got_wait++;
      if (ctrl_op_out != NOOP) pulses++;
    end
    chk("resp_latency", got_wait, exp_wait);
    chk("resp_valid", resp_valid, 1);
    chk("resp_status", resp_status, exp_st);
    chk("resp_value", resp_value, exp_val);
    chk("op_pulse_count", pulses, (op == NOOP) ? 0 : 1);

    for (int s = 0; s < stall; s++) begin
      resp_ready      = 1'b0;
      ctrl_rdy_in     = 1'($urandom);
      ctrl_op_succ_in = 1'($urandom);
      rd_value_in     = $urandom;
      if (hold_req) begin
        req_valid = 1'b1; req_op = READ; req_key = 16'($urandom);
      end
      @(posedge clk); #1;
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_status", resp_status, exp_st);
      chk("stall_value", resp_value, exp_val);
      chk("stall_key_held", key_out, key);
      chk("stall_value_held", value_out, val);
      chk("stall_req_ready", req_ready, 0);
    end

    resp_ready = 1'b1;
    if (hold_req) begin
      req_valid = 1'b1; req_op = READ; req_key = 16'($urandom);
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_resp_valid", resp_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_key_held", key_out, key);
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = NOOP; req_key = '0; req_value = '0;
    resp_ready = 1'b0; ctrl_rdy_in = 1'b0; ctrl_op_succ_in = 1'b0; rd_value_in = '0;
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_status", resp_status, OK);
    chk("rst_value", resp_value, 0);
    chk("rst_ctrl_op", ctrl_op_out, NOOP);
    chk("rst_key_out", key_out, 0);
    chk("rst_value_out", value_out, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // READ hit, ready rises in the 3rd WAIT cycle.
    run_txn(READ, 16'h00A5, 32'h0, 1'b0, 8'b1111_1100, 1'b1, 32'hDEADBEEF, 1, 1'b0);
    // UPSERT miss with stall.
    run_txn(UPSERT, 16'h0011, 32'h12345678, 1'b0, 8'b0000_0010, 1'b0, 32'hCAFEF00D, 3, 1'b0);
    // DELETE timeout, ready never rises.
    run_txn(DELETE, 16'h0042, 32'h0, 1'b0, 8'h00, 1'b1, 32'h11111111, 0, 1'b0);
    // Stale high ready: high, drop, low, rise; 5 stall cycles.
    run_txn(READ, 16'h0777, 32'h0, 1'b1, 8'b1111_1001, 1'b1, 32'hA5A55A5A, 5, 1'b0);
    // Ready held high the whole time: stale level only, times out.
    run_txn(READ, 16'h0778, 32'h0, 1'b1, 8'hFF, 1'b1, 32'h01020304, 0, 1'b0);
    // Edge on the last WAIT cycle beats the timeout.
    run_txn(READ, 16'h0779, 32'h0, 1'b0, 8'b1000_0000, 1'b1, 32'h0BADCAFE, 0, 1'b0);
    // NOOP is illegal; request held through RESP, then back-to-back UPSERT.
    run_txn(NOOP, 16'h1234, 32'h55AA55AA, 1'b0, 8'hFF, 1'b1, 32'h0, 3, 1'b1);
    run_txn(UPSERT, 16'h4321, 32'h87654321, 1'b0, 8'b0000_0001, 1'b1, 32'h99999999, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      bit [TO-1:0] pat;
      pat = ($urandom_range(0, 4) == 0) ? '0 : TO'($urandom);
      run_txn(operation_e'($urandom_range(0, 3)), 16'($urandom), $urandom,
              1'($urandom), pat, 1'($urandom), $urandom,
              $urandom_range(0, 3), 1'($urandom));
    end

    // Reset in the middle of WAIT aborts with no response.
    req_valid = 1'b1; req_op = READ; req_key = 16'h0BAD; req_value = 32'h0; ctrl_rdy_in = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_wait_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_ctrl_op", ctrl_op_out, NOOP);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ctrl_rdy_in = 1'b1; ctrl_op_succ_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_rst_resp_valid", resp_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    ctrl_rdy_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
